debounce_bus_multi: RTL and testbench
=====================================

Name: debounce_bus_multi

Overview:
Parametrised multi-channel bus debouncer. It is the successor to the team's single 16-bit bus debouncer: channel count, width and stability window are generic, and it adds a sample-enable tick, a deadband filter, per-channel stable flags and an update strobe. It sits between noisy multi-bit sources (speed/operand buses, switch banks) and the downstream operation logic. Channels are fully independent.

Parameters:
WIDTH, 16, bits per channel.
CHANNELS, 2, number of independent channels.
STABLE_CYCLES, 10, consecutive matching samples required to commit (legal range 1..255).
DEADBAND, 0, unsigned magnitude; a committed change must satisfy |candidate - clean| > DEADBAND.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
sample_en  input  1  sample tick; state advances only on edges where it is 1.
noisy_in  input  CHANNELS*WIDTH  raw inputs; channel i occupies bits [i*WIDTH +: WIDTH].
clean_out  output  CHANNELS*WIDTH  debounced values, same packing as noisy_in.
stable  output  CHANNELS  level; 1 while the channel's candidate has been held for the full window.
update  output  CHANNELS  one-clock pulse when clean_out of that channel changes.

Behaviour:
- Per-channel state: candidate reg (WIDTH), counter cnt (localparam width = clog2(STABLE_CYCLES+1)), clean reg, stable reg, update reg.
- Reset (async, reset_n=0): candidate=0, cnt=0, clean_out=0, stable=0, update=0 for all channels, applied immediately without a clock edge. Reset mid-count discards all progress.
- Edge with sample_en=0: all state holds; update=0.
- Edge with sample_en=1, per channel:
  - If in != candidate: candidate<=in, cnt<=0, stable<=0, update<=0.
  - Else if cnt < STABLE_CYCLES-1: cnt<=cnt+1, update<=0.
  - Else if cnt == STABLE_CYCLES-1 (commit edge): cnt<=STABLE_CYCLES, stable<=1.
    - If |candidate - clean| > DEADBAND: clean<=candidate, update<=1.
    - Otherwise clean holds and update stays 0 (change rejected; stable still goes 1).
  - Else (cnt == STABLE_CYCLES, saturated): hold; update<=0. A commit happens only once per candidate.
- Latency: let edge E0 be the sample edge that loads a new candidate. If the input stays equal on the next STABLE_CYCLES sample edges, clean_out and update change on the STABLE_CYCLES-th such edge. With sample_en tied 1 and STABLE_CYCLES=10, that is the 10th edge after E0.
- The difference is computed unsigned in WIDTH+1 bits with no wrap. For example, 0xFFFF vs 0x0000 has magnitude 65535.
- With DEADBAND=0, any differing committed value updates. A committed candidate equal to clean never pulses update.
- After reset, an input held at 0 commits silently: stable goes 1, update stays 0.
- A single sample edge mismatching the candidate restarts the window. There is no partial credit.
- update is registered, lasts exactly one clock, and can only assert on a sample_en edge.
- Channels share clock, reset_n and sample_en only; activity on one channel never affects another.

Test Plan:
1. All tests use WIDTH=16, CHANNELS=2, STABLE_CYCLES=10, DEADBAND=0, sample_en=1 unless stated. Hold reset_n=0 with ch0=0x1234 -> clean_out=0, stable=0, update=0. Release and keep ch0=0x1234 -> clean ch0=0x1234 on the 10th edge after the loading edge, update[0] high exactly 1 clock, stable[0]=1 thereafter.
2. Toggle ch0 between 0x00FF and 0x0F00 every 5 clocks for 40 clocks -> clean unchanged, no update, stable[0]=0. Then hold 0x0F00 -> commit 10 edges after the last change.
3. Instance with DEADBAND=4: clean=100, hold input 103 for 20 clocks -> clean stays 100, stable=1, no update. Hold 105 -> clean=105 with an update pulse. Separately step 0xFFFF->0x0000 -> commit (magnitude 65535).
4. sample_en pulsed every 4th clock, hold ch1=0xBEEF -> commit on the 10th matching sample edge (~40 clocks). update[1] coincides with a sample_en edge. No state change on non-sample edges.
5. ch1 bouncing continuously while ch0 steps 0x0001->0x0002 -> ch0 commits on schedule, ch1 clean and stable unchanged.
6. Assert reset_n low asynchronously at cnt=7 between clock edges -> outputs clear immediately. After release, the full 10-sample window is required again.

Source files
------------

// File: rtl/debounce_bus_multi.sv
// Multi-channel bus debouncer: commits a channel's input to clean_out
// once it has held for STABLE_CYCLES sample ticks and moved past DEADBAND.
//
// Ports:
//   clock      rising-edge system clock
//   reset_n    asynchronous active-low reset
//   sample_en  sample tick; state advances only when high
//   noisy_in   raw inputs, channel i at [i*WIDTH +: WIDTH]
//   clean_out  debounced values, same packing as noisy_in
//   stable     per-channel level, candidate held for the full window
//   update     per-channel one-clock pulse when clean_out changes
module debounce_bus_multi #(
  parameter int WIDTH         = 16,
  parameter int CHANNELS      = 2,
  parameter int STABLE_CYCLES = 10,
  parameter int DEADBAND      = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      sample_en,
  input  logic [CHANNELS*WIDTH-1:0] noisy_in,
  output logic [CHANNELS*WIDTH-1:0] clean_out,
  output logic [CHANNELS-1:0]       stable,
  output logic [CHANNELS-1:0]       update
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(STABLE_CYCLES);
  localparam logic [WIDTH:0] DB = (WIDTH + 1)'(DEADBAND);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_clean;
    logic [CW-1:0]    r_cnt;
    logic             r_stable;
    logic             r_update;

    logic [WIDTH-1:0] w_in;
    logic [WIDTH:0]   w_cand_x;
    logic [WIDTH:0]   w_clean_x;
    logic [WIDTH:0]   w_mag;
    logic             w_accept;

    assign w_in      = noisy_in[ch*WIDTH +: WIDTH];
    assign w_cand_x  = {1'b0, r_cand};
    assign w_clean_x = {1'b0, r_clean};

    // Magnitude taken one bit wider so full-scale steps never wrap.
    assign w_mag = (r_cand >= r_clean) ?
                   (w_cand_x - w_clean_x) :
                   (w_clean_x - w_cand_x);
    assign w_accept = (w_mag > DB);

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_cand   <= '0;
        r_clean  <= '0;
        r_cnt    <= '0;
        r_stable <= 1'b0;
        r_update <= 1'b0;
      end else begin
        r_update <= 1'b0;
        if (sample_en) begin
          if (w_in != r_cand) begin
            r_cand   <= w_in;
            r_cnt    <= '0;
            r_stable <= 1'b0;
          end else if (r_cnt < LAST) begin
            r_cnt <= r_cnt + CW'(1);
          end else if (r_cnt == LAST) begin
            // Commit once per candidate; counter then parks at FULL.
            r_cnt    <= FULL;
            r_stable <= 1'b1;
            if (w_accept) begin
              r_clean  <= r_cand;
              r_update <= 1'b1;
            end
          end
        end
      end
    end

    assign clean_out[ch*WIDTH +: WIDTH] = r_clean;
    assign stable[ch] = r_stable;
    assign update[ch] = r_update;
  end

endmodule

// File: tb/tb_debounce_bus_multi.sv
// Directed bench for debounce_bus_multi: default instance plus a
// DEADBAND=4 instance, each with its own reset and stimulus.
module tb_debounce_bus_multi;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst0_n;
  logic        se0;
  logic [31:0] in0;
  logic [31:0] out0;
  logic [1:0]  st0;
  logic [1:0]  up0;

  logic        rst1_n;
  logic        se1;
  logic [31:0] in1;
  logic [31:0] out1;
  logic [1:0]  st1;
  logic [1:0]  up1;

  int checks = 0;
  int errors = 0;

  debounce_bus_multi #(
    .WIDTH(16), .CHANNELS(2), .STABLE_CYCLES(10), .DEADBAND(0)
  ) u_dut0 (
    .clock(clock), .reset_n(rst0_n), .sample_en(se0),
    .noisy_in(in0), .clean_out(out0), .stable(st0), .update(up0)
  );

  debounce_bus_multi #(
    .WIDTH(16), .CHANNELS(2), .STABLE_CYCLES(10), .DEADBAND(4)
  ) u_dut1 (
    .clock(clock), .reset_n(rst1_n), .sample_en(se1),
    .noisy_in(in1), .clean_out(out1), .stable(st1), .update(up1)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    logic [15:0] exp_c;
    rst0_n = 1'b1;
    se0 = 1'b1;
    in0 = {16'h0000, 16'h1234};
    #3;
    rst0_n = 1'b0;
    #2;
    checks++;
    if (out0 !== 32'h0) begin
      errors++;
      $display("FAIL rst_clean got %h exp %h", out0, 32'h0);
    end
    checks++;
    if (st0 !== 2'b00) begin
      errors++;
      $display("FAIL rst_stable got %b exp %b", st0, 2'b00);
    end
    checks++;
    if (up0 !== 2'b00) begin
      errors++;
      $display("FAIL rst_update got %b exp %b", up0, 2'b00);
    end
    tick();
    tick();
    checks++;
    if (out0 !== 32'h0) begin
      errors++;
      $display("FAIL rst_hold got %h exp %h", out0, 32'h0);
    end
    rst0_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_c = (k >= 11) ? 16'h1234 : 16'h0000;
      checks++;
      if (out0[15:0] !== exp_c) begin
        errors++;
        $display("FAIL t1_clean k=%0d got %h exp %h", k, out0[15:0], exp_c);
      end
      checks++;
      if (up0[0] !== (k == 11)) begin
        errors++;
        $display("FAIL t1_upd0 k=%0d got %b exp %b", k, up0[0], k == 11);
      end
      checks++;
      if (st0[0] !== (k >= 11)) begin
        errors++;
        $display("FAIL t1_st0 k=%0d got %b exp %b", k, st0[0], k >= 11);
      end
      checks++;
      if (st0[1] !== (k >= 10) || up0[1] !== 1'b0) begin
        errors++;
        $display("FAIL t1_ch1_silent k=%0d got st=%b up=%b exp st=%b up=0",
                 k, st0[1], up0[1], k >= 10);
      end
    end
  endtask

  task automatic test_bounce;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0)
        in0[15:0] = ((i / 5) % 2 == 0) ? 16'h00FF : 16'h0F00;
      tick();
      checks++;
      if (out0[15:0] !== 16'h1234 || up0[0] !== 1'b0 || st0[0] !== 1'b0)
      begin
        errors++;
        $display("FAIL t2_bounce i=%0d got c=%h u=%b s=%b exp c=1234 u=0 s=0",
                 i, out0[15:0], up0[0], st0[0]);
      end
    end
    // Last load was at i=35; four edges already matched.
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (out0[15:0] !== ((k == 6) ? 16'h0F00 : 16'h1234)) begin
        errors++;
        $display("FAIL t2_settle k=%0d got %h exp %h", k, out0[15:0],
                 (k == 6) ? 16'h0F00 : 16'h1234);
      end
      checks++;
      if (up0[0] !== (k == 6)) begin
        errors++;
        $display("FAIL t2_upd k=%0d got %b exp %b", k, up0[0], k == 6);
      end
    end
  endtask

  task automatic test_independent;
    in0[15:0] = 16'h0001;
    for (int k = 1; k <= 11; k++) begin
      in0[31:16] = (k % 2 == 1) ? 16'h5555 : 16'hAAAA;
      tick();
    end
    checks++;
    if (out0[15:0] !== 16'h0001 || up0[0] !== 1'b1) begin
      errors++;
      $display("FAIL t5_first got c=%h u=%b exp c=0001 u=1",
               out0[15:0], up0[0]);
    end
    in0[15:0] = 16'h0002;
    for (int k = 1; k <= 11; k++) begin
      in0[31:16] = (k % 2 == 1) ? 16'h5555 : 16'hAAAA;
      tick();
      checks++;
      if (out0[31:16] !== 16'h0000 || st0[1] !== 1'b0 || up0[1] !== 1'b0)
      begin
        errors++;
        $display("FAIL t5_ch1 k=%0d got c=%h s=%b u=%b exp c=0000 s=0 u=0",
                 k, out0[31:16], st0[1], up0[1]);
      end
      checks++;
      if (out0[15:0] !== ((k == 11) ? 16'h0002 : 16'h0001) ||
          up0[0] !== (k == 11)) begin
        errors++;
        $display("FAIL t5_ch0 k=%0d got c=%h u=%b exp c=%h u=%b",
                 k, out0[15:0], up0[0],
                 (k == 11) ? 16'h0002 : 16'h0001, k == 11);
      end
    end
  endtask

  task automatic test_sample_en;
    in0[31:16] = 16'hBEEF;
    for (int j = 0; j <= 44; j++) begin
      se0 = (j % 4 == 0);
      tick();
      checks++;
      if (up0[1] !== (j == 40)) begin
        errors++;
        $display("FAIL t4_upd j=%0d got %b exp %b", j, up0[1], j == 40);
      end
      checks++;
      if (out0[31:16] !== ((j >= 40) ? 16'hBEEF : 16'h0000) ||
          st0[1] !== (j >= 40)) begin
        errors++;
        $display("FAIL t4_state j=%0d got c=%h s=%b exp c=%h s=%b",
                 j, out0[31:16], st0[1],
                 (j >= 40) ? 16'hBEEF : 16'h0000, j >= 40);
      end
    end
    checks++;
    if (out0[15:0] !== 16'h0002 || up0[0] !== 1'b0) begin
      errors++;
      $display("FAIL t4_ch0 got c=%h u=%b exp c=0002 u=0",
               out0[15:0], up0[0]);
    end
    se0 = 1'b1;
  endtask

  task automatic test_async_reset;
    in0[15:0] = 16'h4321;
    for (int k = 1; k <= 8; k++) tick();
    checks++;
    if (out0[15:0] !== 16'h0002) begin
      errors++;
      $display("FAIL t6_pre got %h exp %h", out0[15:0], 16'h0002);
    end
    #2;
    rst0_n = 1'b0;
    #1;
    checks++;
    if (out0 !== 32'h0 || st0 !== 2'b00 || up0 !== 2'b00) begin
      errors++;
      $display("FAIL t6_async got c=%h s=%b u=%b exp all zero",
               out0, st0, up0);
    end
    tick();
    rst0_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (out0[15:0] !== ((k == 11) ? 16'h4321 : 16'h0000) ||
          up0[0] !== (k == 11)) begin
        errors++;
        $display("FAIL t6_window k=%0d got c=%h u=%b exp c=%h u=%b",
                 k, out0[15:0], up0[0],
                 (k == 11) ? 16'h4321 : 16'h0000, k == 11);
      end
    end
  endtask

  task automatic test_deadband;
    se1 = 1'b1;
    in1 = {16'h0000, 16'd100};
    rst1_n = 1'b0;
    tick();
    tick();
    rst1_n = 1'b1;
    for (int k = 1; k <= 11; k++) tick();
    checks++;
    if (out1[15:0] !== 16'd100 || up1[0] !== 1'b1) begin
      errors++;
      $display("FAIL t3_init got c=%0d u=%b exp c=100 u=1",
               out1[15:0], up1[0]);
    end
    in1[15:0] = 16'd103;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (up1[0] !== 1'b0 || out1[15:0] !== 16'd100) begin
        errors++;
        $display("FAIL t3_reject k=%0d got c=%0d u=%b exp c=100 u=0",
                 k, out1[15:0], up1[0]);
      end
    end
    checks++;
    if (st1[0] !== 1'b1) begin
      errors++;
      $display("FAIL t3_rej_stable got %b exp 1", st1[0]);
    end
    in1[15:0] = 16'd105;
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (up1[0] !== (k == 11) ||
          out1[15:0] !== ((k == 11) ? 16'd105 : 16'd100)) begin
        errors++;
        $display("FAIL t3_accept k=%0d got c=%0d u=%b exp c=%0d u=%b",
                 k, out1[15:0], up1[0],
                 (k == 11) ? 16'd105 : 16'd100, k == 11);
      end
    end
    in1[15:0] = 16'hFFFF;
    for (int k = 1; k <= 11; k++) tick();
    checks++;
    if (out1[15:0] !== 16'hFFFF || up1[0] !== 1'b1) begin
      errors++;
      $display("FAIL t3_ffff got c=%h u=%b exp c=ffff u=1",
               out1[15:0], up1[0]);
    end
    in1[15:0] = 16'h0000;
    for (int k = 1; k <= 11; k++) tick();
    checks++;
    if (out1[15:0] !== 16'h0000 || up1[0] !== 1'b1) begin
      errors++;
      $display("FAIL t3_wrap got c=%h u=%b exp c=0000 u=1",
               out1[15:0], up1[0]);
    end
    // Exactly DEADBAND away is still inside the band.
    in1[15:0] = 16'd4;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (up1[0] !== 1'b0 || out1[15:0] !== 16'd0) begin
        errors++;
        $display("FAIL t3_edge k=%0d got c=%0d u=%b exp c=0 u=0",
                 k, out1[15:0], up1[0]);
      end
    end
    checks++;
    if (st1[0] !== 1'b1) begin
      errors++;
      $display("FAIL t3_edge_stable got %b exp 1", st1[0]);
    end
  endtask

  initial begin
    rst1_n = 1'b1;
    se1 = 1'b0;
    in1 = '0;
    test_reset();
    test_bounce();
    test_independent();
    test_sample_en();
    test_async_reset();
    test_deadband();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
